vend_ctrl: RTL and testbench
============================

# vend_ctrl

Session controller for the coin-operated vending datapath. It arbitrates coin insertions from two independent coin slots into one credit accumulator, and sequences the product-dispense handshake with the motor driver. It also pays back change or a timed-out refund in half-unit pulses and tracks remaining stock. It sits between the coin acceptors and the dispenser/change hopper; all amounts are counted in half-units (0.5 yuan).

## Interface
Parameters:
- PRICE_HALVES, 5, product price in half-units (5 = 2.5 yuan); legal range 2..13
- STOCK_INIT, 8, stock count loaded at reset; legal range 1..255
- TIMEOUT, 200, idle cycles with nonzero credit before a full refund; legal range ≥ 2
- CREDIT_W, 4, credit register width; must hold PRICE_HALVES+1

Ports:
- sys_clk  in  1  clock, rising edge
- sys_rst_n  in  1  asynchronous, active-low reset
- pay  in  2  per-slot 1-yuan coin pulse (bit i = slot i), one cycle wide
- pay_half  in  2  per-slot 0.5-yuan coin pulse, one cycle wide
- disp_ack  in  1  dispenser done, one-cycle pulse, only meaningful while disp_req=1
- grant  out  2  one-hot pulse: the slot whose coin was credited this cycle
- coin_rej  out  2  per-slot pulse: the coin was rejected and returned mechanically
- disp_req  out  1  dispense request, level, held until disp_ack
- coke  out  1  one-cycle pulse: product delivered
- ret  out  1  one-cycle pulse: hopper returns one 0.5-yuan coin
- credit  out  CREDIT_W  current accumulated credit, in half-units
- stock  out  8  remaining products
- sold_out  out  1  stock == 0

## Operation
- Per-slot pending register: value 0 = empty, 1 = half-unit, 2 = one yuan.
- A coin pulse on an empty slot loads the register. If pay and pay_half fire together on one slot, the slot takes pay and rejects pay_half.
- A pulse on a slot whose register is full gives coin_rej[i] for 1 cycle; the pending coin is kept.
- When sold_out=1, every coin pulse is rejected and nothing is loaded.
- FSM states: IDLE, DISP, CHG, REFUND.
- IDLE:
  - At most one pending coin is granted per cycle, round-robin; after reset slot 0 has priority.
  - A grant adds the coin value to credit, clears that register and flips priority to the other slot.
  - If the updated credit ≥ PRICE_HALVES → DISP.
- DISP:
  - disp_req=1, no grants. When disp_ack=1: coke pulses, stock decrements, credit -= PRICE_HALVES.
  - If the remainder is > 0 → CHG, else → IDLE.
- CHG and REFUND:
  - Each cycle: ret=1, credit decrements by 1. When credit reaches 0 → IDLE.
  - No grants in either state; pending coins wait.
- Timeout:
  - Idle counter runs in IDLE while credit > 0 and no grant occurs. A grant or credit == 0 clears it.
  - When the counter reaches TIMEOUT-1 → REFUND.
- If stock reaches 0 with credit 0, IDLE stays put; any pending coins remain in their registers until reset.
- Width rule: maximum credit = PRICE_HALVES-1+2, so no overflow at legal parameters.

## Timing
- Reset values: all outputs 0 except stock=STOCK_INIT and sold_out=(STOCK_INIT==0). FSM=IDLE, pending registers empty, priority = slot 0.
- Coin pulse at edge n → pending at n+1 → earliest grant and credit update at n+1. So grant is visible in the cycle after the pulse, and credit updates at the following edge.
- Grant that reaches price → disp_req=1 in the next cycle.
- disp_ack sampled at edge k → coke=1 and the stock/credit update visible after edge k. The first ret follows one cycle later if change is due.
- disp_req is held indefinitely without disp_ack; the timeout counter is frozen outside IDLE.
- A coin arriving in the same cycle that its slot is granted is accepted into the freed register, not rejected.
- Reset mid-dispense or mid-change aborts immediately; credit is lost and outputs return to reset values.

## Test plan
- Slot 0: pay ×2, then pay_half, default params → three grants, credit 2→4→5, disp_req; disp_ack → coke=1, stock 8→7, no ret, back to IDLE.
- Slot 0: pay ×2, slot 1: pay in the same cycle as slot 0's first coin → grants alternate 0,1,0. Credit 2,4,6 → DISP; after ack, one ret pulse, credit 0.
- Slot 1: pay on two consecutive cycles while stalled in DISP → first coin held, second gives coin_rej[1]=1. The held coin is granted after returning to IDLE.
- pay_half once, then silence → after TIMEOUT cycles REFUND, exactly one ret, credit 0.
- STOCK_INIT=1: buy once → sold_out=1; subsequent pay → coin_rej, credit stays 0.
- Assert sys_rst_n=0 during CHG with credit 1 → ret=0, credit 0, stock reloads STOCK_INIT, FSM IDLE.

Source files
------------

// File: rtl/vend_ctrl.sv
// vend_ctrl: session controller for the coin-operated vending datapath.
// Arbitrates two coin slots into one credit accumulator (round-robin), runs the
// dispense handshake and pays back change or a timed-out refund in half-unit pulses.
// All amounts are in half-units (0.5 yuan).
//
// Ports:
//   sys_clk, sys_rst_n   clock (rising edge), asynchronous active-low reset
//   pay[1:0]             per-slot 1-yuan coin pulse
//   pay_half[1:0]        per-slot 0.5-yuan coin pulse
//   disp_ack             dispenser done pulse (meaningful while disp_req=1)
//   grant[1:0]           one-hot: slot whose pending coin is credited this cycle
//   coin_rej[1:0]        per-slot reject pulse (cycle after the offending coin)
//   disp_req             dispense request level, held until disp_ack
//   coke                 product delivered pulse
//   ret                  hopper returns one half-unit coin
//   credit               accumulated credit
//   stock, sold_out      remaining products, stock == 0
module vend_ctrl #(
  parameter int unsigned PRICE_HALVES = 5,
  parameter int unsigned STOCK_INIT   = 8,
  parameter int unsigned TIMEOUT      = 200,
  parameter int unsigned CREDIT_W     = 4
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [1:0]          pay,
  input  logic [1:0]          pay_half,
  input  logic                disp_ack,
  output logic [1:0]          grant,
  output logic [1:0]          coin_rej,
  output logic                disp_req,
  output logic                coke,
  output logic                ret,
  output logic [CREDIT_W-1:0] credit,
  output logic [7:0]          stock,
  output logic                sold_out
);

  localparam int unsigned TimerW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StDisp, StChg, StRefund} state_e;

  state_e              state_q, state_d;
  logic [1:0][1:0]     pend_q, pend_d;   // 0 empty, 1 half-unit, 2 one yuan
  logic                prio_q, prio_d;   // 0: slot 0 preferred, 1: slot 1 preferred
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [7:0]          stock_q, stock_d;
  logic [TimerW-1:0]   cnt_q, cnt_d;
  logic [1:0]          rej_q, rej_d;
  logic                coke_q, coke_d;
  logic                ret_q, ret_d;
  logic [1:0]          avail;
  logic [1:0]          gval;
  logic [CREDIT_W-1:0] sum;

  assign sold_out = (stock_q == 8'd0);

  // Round-robin grant; nothing is granted outside IDLE or once sold out.
  always_comb begin
    avail = {pend_q[1] != 2'd0, pend_q[0] != 2'd0};
    grant = 2'b00;
    if (state_q == StIdle && !sold_out) begin
      if (avail[0] && (!prio_q || !avail[1])) grant = 2'b01;
      else if (avail[1])                       grant = 2'b10;
    end
  end

  // Pending registers: a slot being granted this cycle counts as free.
  always_comb begin
    pend_d = pend_q;
    rej_d  = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (pay[i] || pay_half[i]) begin
        if (sold_out || (pend_q[i] != 2'd0 && !grant[i])) begin
          rej_d[i] = 1'b1;
        end else begin
          pend_d[i] = pay[i] ? 2'd2 : 2'd1;
          rej_d[i]  = pay[i] & pay_half[i];
        end
      end else if (grant[i]) begin
        pend_d[i] = 2'd0;
      end
    end
  end

  assign gval = grant[1] ? pend_q[1] : pend_q[0];
  assign sum  = credit_q + CREDIT_W'(gval);

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    stock_d  = stock_q;
    cnt_d    = cnt_q;
    prio_d   = prio_q;
    coke_d   = 1'b0;
    ret_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (|grant) begin
          credit_d = sum;
          prio_d   = grant[0];
          cnt_d    = '0;
          if (sum >= CREDIT_W'(PRICE_HALVES)) state_d = StDisp;
        end else if (credit_q == '0) begin
          cnt_d = '0;
        end else if (cnt_q == TimerW'(TIMEOUT - 1)) begin
          cnt_d   = '0;
          state_d = StRefund;
        end else begin
          cnt_d = cnt_q + TimerW'(1);
        end
      end
      StDisp: begin
        if (disp_ack) begin
          coke_d   = 1'b1;
          stock_d  = stock_q - 8'd1;
          credit_d = credit_q - CREDIT_W'(PRICE_HALVES);
          state_d  = (credit_q != CREDIT_W'(PRICE_HALVES)) ? StChg : StIdle;
        end
      end
      StChg, StRefund: begin
        ret_d    = 1'b1;
        credit_d = credit_q - CREDIT_W'(1);
        if (credit_q == CREDIT_W'(1)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= StIdle;
      pend_q   <= '0;
      prio_q   <= 1'b0;
      credit_q <= '0;
      stock_q  <= 8'(STOCK_INIT);
      cnt_q    <= '0;
      rej_q    <= 2'b00;
      coke_q   <= 1'b0;
      ret_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      prio_q   <= prio_d;
      credit_q <= credit_d;
      stock_q  <= stock_d;
      cnt_q    <= cnt_d;
      rej_q    <= rej_d;
      coke_q   <= coke_d;
      ret_q    <= ret_d;
    end
  end

  assign coin_rej = rej_q;
  assign disp_req = (state_q == StDisp);
  assign coke     = coke_q;
  assign ret      = ret_q;
  assign credit   = credit_q;
  assign stock    = stock_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Self-checking bench for vend_ctrl: directed scenarios followed by randomized coin
// traffic, every cycle compared against a behavioural model of the vending session.
module tb_vend_ctrl;

  localparam int Price     = 5;
  localparam int StockInit = 8;
  localparam int Timeout   = 200;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [1:0] pay = 2'b00;
  logic [1:0] pay_half = 2'b00;
  logic       disp_ack = 1'b0;
  logic [1:0] grant, coin_rej;
  logic       disp_req, coke, ret, sold_out;
  logic [3:0] credit;
  logic [7:0] stock;

  vend_ctrl #(
    .PRICE_HALVES(Price),
    .STOCK_INIT  (StockInit),
    .TIMEOUT     (Timeout),
    .CREDIT_W    (4)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .pay      (pay),
    .pay_half (pay_half),
    .disp_ack (disp_ack),
    .grant    (grant),
    .coin_rej (coin_rej),
    .disp_req (disp_req),
    .coke     (coke),
    .ret      (ret),
    .credit   (credit),
    .stock    (stock),
    .sold_out (sold_out)
  );

  always #5 sys_clk = ~sys_clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural model: what the customer session is doing, coins waiting per slot,
  // and the clock edge of the last credited coin (for the inactivity refund).
  typedef enum {Shopping, Vending, PayingBack} activity_e;
  activity_e m_act;
  int        m_pend[2];
  int        m_credit, m_stock, m_next_slot, m_cyc, m_last_grant;
  bit [1:0]  m_rej;
  bit        m_coke, m_ret;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick();
    if (m_act != Shopping || m_stock == 0) return -1;
    if (m_pend[m_next_slot] != 0) return m_next_slot;
    if (m_pend[1 - m_next_slot] != 0) return 1 - m_next_slot;
    return -1;
  endfunction

  task automatic model_reset();
    m_act = Shopping; m_pend[0] = 0; m_pend[1] = 0; m_credit = 0; m_stock = StockInit;
    m_next_slot = 0; m_rej = 2'b00; m_coke = 0; m_ret = 0; m_last_grant = m_cyc;
  endtask

  task automatic model_edge(input logic [1:0] p, input logic [1:0] ph, input logic a);
    int g, gv;
    g  = pick();
    gv = (g >= 0) ? m_pend[g] : 0;
    m_cyc++;
    for (int i = 0; i < 2; i++) begin
      m_rej[i] = 1'b0;
      if (p[i] || ph[i]) begin
        if (m_stock == 0 || (m_pend[i] != 0 && g != i)) m_rej[i] = 1'b1;
        else begin
          m_pend[i] = p[i] ? 2 : 1;
          m_rej[i]  = p[i] & ph[i];
        end
      end else if (g == i) m_pend[i] = 0;
    end
    m_coke = 0;
    m_ret  = 0;
    case (m_act)
      Shopping: begin
        if (g >= 0) begin
          m_credit += gv;
          m_next_slot = 1 - g;
          m_last_grant = m_cyc;
          if (m_credit >= Price) m_act = Vending;
        end else if (m_credit > 0 && m_cyc - m_last_grant == Timeout) m_act = PayingBack;
      end
      Vending: if (a) begin
        m_coke = 1; m_stock--; m_credit -= Price;
        m_act = (m_credit > 0) ? PayingBack : Shopping;
      end
      default: begin
        m_ret = 1; m_credit--;
        if (m_credit == 0) m_act = Shopping;
      end
    endcase
  endtask

  task automatic check_outputs();
    int g;
    g = pick();
    chk("grant", 32'(grant), (g < 0) ? 0 : (1 << g));
    chk("coin_rej", 32'(coin_rej), 32'(m_rej));
    chk("disp_req", 32'(disp_req), 32'(m_act == Vending));
    chk("coke", 32'(coke), 32'(m_coke));
    chk("ret", 32'(ret), 32'(m_ret));
    chk("credit", 32'(credit), m_credit);
    chk("stock", 32'(stock), m_stock);
    chk("sold_out", 32'(sold_out), 32'(m_stock == 0));
  endtask

  // Called at a falling edge: check, drive, take the rising edge, return at the next fall.
  task automatic step(input logic [1:0] p, input logic [1:0] ph, input logic a);
    check_outputs();
    pay = p; pay_half = ph; disp_ack = a;
    @(posedge sys_clk);
    model_edge(p, ph, a);
    @(negedge sys_clk);
    pay = 2'b00; pay_half = 2'b00; disp_ack = 1'b0;
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0; pay = 2'b00; pay_half = 2'b00; disp_ack = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  int rets;
  int bound;

  initial begin
    m_cyc = 0;
    @(negedge sys_clk);
    do_reset();

    // Single slot: 1 + 1 + 0.5 yuan reaches price exactly, no change.
    step(2'b01, 2'b00, 0); step(2'b01, 2'b00, 0); step(2'b00, 2'b01, 0); step(2'b00, 2'b00, 0);
    chk("t1_credit", 32'(credit), 5);
    chk("t1_disp_req", 32'(disp_req), 1);
    step(2'b00, 2'b00, 1);
    chk("t1_coke", 32'(coke), 1);
    chk("t1_stock", 32'(stock), 7);
    step(2'b00, 2'b00, 0);
    chk("t1_no_ret", 32'(ret), 0);
    chk("t1_idle", 32'(disp_req), 0);

    // Two slots alternate 0,1,0; credit 6 gives one half-unit of change.
    do_reset();
    step(2'b11, 2'b00, 0);
    chk("t2_grant_a", 32'(grant), 1);
    step(2'b01, 2'b00, 0);
    chk("t2_credit_a", 32'(credit), 2);
    chk("t2_grant_b", 32'(grant), 2);
    step(2'b00, 2'b00, 0);
    chk("t2_credit_b", 32'(credit), 4);
    chk("t2_grant_c", 32'(grant), 1);
    step(2'b00, 2'b00, 0);
    chk("t2_credit_c", 32'(credit), 6);
    step(2'b00, 2'b00, 1);
    chk("t2_credit_d", 32'(credit), 1);
    step(2'b00, 2'b00, 0);
    chk("t2_ret", 32'(ret), 1);
    chk("t2_credit_e", 32'(credit), 0);
    step(2'b00, 2'b00, 0);
    chk("t2_ret_end", 32'(ret), 0);

    // Same purchase again, reset while paying change with credit 1.
    do_reset();
    step(2'b11, 2'b00, 0); step(2'b01, 2'b00, 0); step(2'b00, 2'b00, 0); step(2'b00, 2'b00, 0);
    step(2'b00, 2'b00, 1);
    chk("t6_pre_credit", 32'(credit), 1);
    do_reset();
    chk("t6_ret", 32'(ret), 0);
    chk("t6_credit", 32'(credit), 0);
    chk("t6_stock", 32'(stock), StockInit);
    chk("t6_idle", 32'(disp_req), 0);

    // Coins on slot 1 while stalled in DISP: first held, second rejected.
    step(2'b01, 2'b00, 0); step(2'b01, 2'b00, 0); step(2'b00, 2'b01, 0); step(2'b00, 2'b00, 0);
    step(2'b10, 2'b00, 0); step(2'b10, 2'b00, 0);
    chk("t3_rej", 32'(coin_rej), 2);
    chk("t3_stall", 32'(disp_req), 1);
    step(2'b00, 2'b00, 1);
    chk("t3_grant", 32'(grant), 2);
    step(2'b00, 2'b00, 0);
    chk("t3_credit", 32'(credit), 2);

    // One half-unit then silence: refund only after the inactivity window.
    do_reset();
    step(2'b00, 2'b01, 0); step(2'b00, 2'b00, 0);
    rets = 0;
    for (int k = 1; k <= Timeout; k++) begin
      step(2'b00, 2'b00, 0);
      if (ret === 1'b1) rets++;
    end
    chk("t4_early_ret", rets, 0);
    for (int k = 0; k < 5; k++) begin
      step(2'b00, 2'b00, 0);
      if (ret === 1'b1) rets++;
    end
    chk("t4_ret_count", rets, 1);
    chk("t4_credit", 32'(credit), 0);

    // Sell the whole stock, then every coin is rejected.
    do_reset();
    for (int b = 0; b < StockInit; b++) begin
      bound = 0;
      while (m_act != Vending && bound < 20) begin step(2'b01, 2'b00, 0); bound++; end
      step(2'b00, 2'b00, 1);
      while (m_act != Shopping && bound < 40) begin step(2'b00, 2'b00, 0); bound++; end
      chk("t5_buy_bound", 32'(bound < 40), 1);
    end
    chk("t5_sold_out", 32'(sold_out), 1);
    chk("t5_stock", 32'(stock), 0);
    step(2'b11, 2'b11, 0);
    chk("t5_rej", 32'(coin_rej), 3);
    step(2'b00, 2'b00, 0);
    chk("t5_credit", 32'(credit), 0);
    chk("t5_no_grant", 32'(grant), 0);

    // Random coin traffic with a quiet window so refunds also occur.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int c = 0; c < 700; c++) begin
        logic [1:0] p, ph;
        logic a;
        p  = {1'($urandom_range(5) == 0), 1'($urandom_range(5) == 0)};
        ph = {1'($urandom_range(5) == 0), 1'($urandom_range(5) == 0)};
        if (c >= 300 && c < 520) begin p = 2'b00; ph = 2'b00; end
        a = (m_act == Vending) && ($urandom_range(2) == 0);
        step(p, ph, a);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
